ntt_coeff_loader: RTL and testbench

//  Ingest stage in front of parallel_ntt_core. Accepts a valid/ready stream of raw 64-bit

---
 rtl/ntt_coeff_loader.sv | 117 +++++++++++
 tb/tb_ntt_coeff_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_coeff_loader.sv
// Ingest stage for the NTT core: reduces raw coefficients mod MODULUS and writes them (optionally
// bit-reversed) into the core, pads short frames with zeros, kicks the core, then waits for ntt_done.
module ntt_coeff_loader #(
  parameter int unsigned       LOGN        = 12,
  parameter int unsigned       WIDTH       = 64,
  parameter logic [WIDTH-1:0]  MODULUS     = 64'hffffffff00000001,
  parameter int unsigned       BIT_REVERSE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             coeff_valid,
  output logic [WIDTH-1:0] coeff_data,
  output logic [LOGN-1:0]  coeff_addr,
  output logic             start_ntt,
  input  logic             ntt_done,
  output logic             frame_err,
  output logic [31:0]      frames_loaded,
  output logic             loader_busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL      = 3'd1,
    PAD       = 3'd2,
    KICK      = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  localparam logic [LOGN-1:0] LAST_IDX = {LOGN{1'b1}};
  localparam logic [LOGN-1:0] IDX_ONE  = {{(LOGN-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [LOGN-1:0]  idx;
  logic             accept;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             err_set;
  logic             kick;

  function automatic logic [LOGN-1:0] map_addr(input logic [LOGN-1:0] i);
    logic [LOGN-1:0] r;
    r = i;
    if (BIT_REVERSE != 0) begin
      for (int b = 0; b < int'(LOGN); b++) r[b] = i[int'(LOGN)-1-b];
    end
    return r;
  endfunction

  // Any 64-bit value is below 2*MODULUS, so a single conditional subtract fully reduces it.
  function automatic logic [WIDTH-1:0] reduce(input logic [WIDTH-1:0] x);
    return (x >= MODULUS) ? (x - MODULUS) : x;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (enable) state_nxt = FILL;
      FILL: begin
        if (accept) begin
          if (s_last && idx != LAST_IDX) state_nxt = PAD;
          else if (idx == LAST_IDX)      state_nxt = KICK;
        end
      end
      PAD:       if (idx == LAST_IDX) state_nxt = KICK;
      KICK:      state_nxt = WAIT_DONE;
      WAIT_DONE: if (ntt_done) state_nxt = enable ? FILL : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready     = (state == FILL);
    loader_busy = (state != IDLE);
    accept      = s_valid && s_ready;
    wr_en       = accept || (state == PAD);
    wr_data     = (state == FILL) ? reduce(s_data) : '0;
    // Both an early s_last and a missing s_last on the final index are flagged.
    err_set     = accept && ((s_last && idx != LAST_IDX) || (!s_last && idx == LAST_IDX));
    kick        = (state == KICK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= '0;
      coeff_valid   <= 1'b0;
      coeff_data    <= '0;
      coeff_addr    <= '0;
      start_ntt     <= 1'b0;
      frame_err     <= 1'b0;
      frames_loaded <= '0;
    end else begin
      coeff_valid <= wr_en;
      start_ntt   <= kick;
      frame_err   <= err_set;
      if (wr_en) begin
        coeff_data <= wr_data;
        coeff_addr <= map_addr(idx);
        idx        <= idx + IDX_ONE;
      end
      if (kick) begin
        idx           <= '0;
        frames_loaded <= frames_loaded + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// Bench for ntt_coeff_loader at LOGN=3 with bit-reversed addressing; writes are scoreboarded.
module tb_ntt_coeff_loader;

  localparam logic [63:0] MOD = 64'hffffffff00000001;

  logic        clk, rst_n, enable, s_valid, s_ready, s_last;
  logic [63:0] s_data, coeff_data;
  logic        coeff_valid, start_ntt, ntt_done, frame_err, loader_busy;
  logic [2:0]  coeff_addr;
  logic [31:0] frames_loaded;

  ntt_coeff_loader #(.LOGN(3), .WIDTH(64), .MODULUS(MOD), .BIT_REVERSE(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .coeff_valid(coeff_valid), .coeff_data(coeff_data), .coeff_addr(coeff_addr),
    .start_ntt(start_ntt), .ntt_done(ntt_done), .frame_err(frame_err),
    .frames_loaded(frames_loaded), .loader_busy(loader_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  addr;
    logic [63:0] data;
  } wr_t;

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic [63:0] exp;
  } vec_t;

  wr_t   q[$];
  int    errs, checks;
  int    n_start, n_err, n_writes;
  logic  prev_cv;
  int    br[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon();
    wr_t w;
    if (coeff_valid) begin
      n_writes++;
      if (q.size() == 0) begin
        chk("unexpected_write", {61'd0, coeff_addr}, 64'hx);
      end else begin
        w = q.pop_front();
        chk("write_addr", {61'd0, coeff_addr}, {61'd0, w.addr});
        chk("write_data", coeff_data, w.data);
      end
    end
    if (start_ntt) begin
      n_start++;
      chk("start_after_last_write", {63'd0, prev_cv}, 64'd1);
      chk("start_not_with_write", {63'd0, coeff_valid}, 64'd0);
    end
    if (frame_err) n_err++;
    prev_cv = coeff_valid;
  endtask

  task automatic cyc(output logic rdy);
    @(negedge clk);
    mon();
    rdy = s_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic r;
    for (int i = 0; i < n; i++) cyc(r);
  endtask

  task automatic beat(input logic [63:0] d, input logic l, input logic [63:0] ed, input int ea);
    logic r;
    int   n;
    wr_t  w;
    w.addr = 3'(ea);
    w.data = ed;
    q.push_back(w);
    s_valid = 1'b1; s_data = d; s_last = l; n = 0;
    do begin
      cyc(r);
      n++;
    end while (!r && n < 200);
    chk("beat_accepted", {63'd0, r}, 64'd1);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_start();
    int s0, n;
    logic r;
    s0 = n_start; n = 0;
    while (n_start == s0 && n < 100) begin
      cyc(r);
      n++;
    end
    chk("start_seen", 64'(n_start - s0), 64'd1);
  endtask

  task automatic pulse_done();
    logic r;
    ntt_done = 1'b1;
    cyc(r);
    ntt_done = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, {63'd0, s_ready}, 64'd0);
    chk({tag, "_coeff_valid"}, {63'd0, coeff_valid}, 64'd0);
    chk({tag, "_coeff_data"}, coeff_data, 64'd0);
    chk({tag, "_coeff_addr"}, {61'd0, coeff_addr}, 64'd0);
    chk({tag, "_start_ntt"}, {63'd0, start_ntt}, 64'd0);
    chk({tag, "_frame_err"}, {63'd0, frame_err}, 64'd0);
    chk({tag, "_frames_loaded"}, {32'd0, frames_loaded}, 64'd0);
    chk({tag, "_busy"}, {63'd0, loader_busy}, 64'd0);
  endtask

  vec_t f1[8];
  vec_t f2[8];

  initial begin
    logic r, stuck;
    int   w0, s0, e0;

    for (int i = 0; i < 8; i++) begin
      f1[i].d = 64'(i); f1[i].l = (i == 7); f1[i].exp = 64'(i);
    end
    f2[0] = '{64'hffffffff00000001, 1'b0, 64'h0};
    f2[1] = '{64'hffffffffffffffff, 1'b0, 64'h00000000fffffffe};
    f2[2] = '{64'hffffffff00000000, 1'b0, 64'hffffffff00000000};
    f2[3] = '{64'hffffffff00000002, 1'b0, 64'h1};
    f2[4] = '{64'h0,                1'b0, 64'h0};
    f2[5] = '{64'h0000000100000000, 1'b0, 64'h0000000100000000};
    f2[6] = '{64'h8000000000000000, 1'b0, 64'h8000000000000000};
    f2[7] = '{64'hfffffffffffffff0, 1'b1, 64'h00000000ffffffef};

    errs = 0; checks = 0; n_start = 0; n_err = 0; n_writes = 0; prev_cv = 1'b0;
    rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; ntt_done = 1'b0;
    #23;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    chk("idle_busy", {63'd0, loader_busy}, 64'd0);
    enable = 1'b1;
    idle(1);

    // Frame 1: in-order data, bit-reversed addresses
    for (int i = 0; i < 8; i++) beat(f1[i].d, f1[i].l, f1[i].exp, br[i]);
    wait_start();
    chk("frames_after_f1", {32'd0, frames_loaded}, 64'd1);
    chk("no_err_f1", 64'(n_err), 64'd0);

    // Core busy: ingest must stay blocked even with s_valid held
    w0 = n_writes; s0 = n_start; stuck = 1'b0;
    s_valid = 1'b1; s_data = 64'h55;
    for (int i = 0; i < 50; i++) begin
      cyc(r);
      stuck |= r;
    end
    chk("hold_ready_low", {63'd0, stuck}, 64'd0);
    chk("hold_no_write", 64'(n_writes - w0), 64'd0);
    chk("hold_single_start", 64'(n_start - s0), 64'd0);
    s_valid = 1'b0;
    pulse_done();
    cyc(r);
    chk("ready_after_done", {63'd0, r}, 64'd1);

    // Frame 2: reduction boundaries; stray ntt_done in FILL ignored
    pulse_done();
    cyc(r);
    chk("stray_done_ignored", {63'd0, r}, 64'd1);
    for (int i = 0; i < 8; i++) beat(f2[i].d, f2[i].l, f2[i].exp, br[i]);
    wait_start();
    chk("frames_after_f2", {32'd0, frames_loaded}, 64'd2);
    enable = 1'b0;
    pulse_done();
    idle(1);
    chk("idle_after_done_disabled", {63'd0, loader_busy}, 64'd0);
    enable = 1'b1;
    idle(1);

    // Frame 3: early s_last at idx 4, zero padding to 5,3,7
    e0 = n_err;
    for (int i = 0; i < 5; i++) beat(64'(100 + i), (i == 4), 64'(100 + i), br[i]);
    for (int i = 5; i < 8; i++) begin
      wr_t w;
      w.addr = 3'(br[i]); w.data = 64'h0;
      q.push_back(w);
    end
    cyc(r);
    chk("pad_ready_low", {63'd0, r}, 64'd0);
    wait_start();
    chk("early_last_err", 64'(n_err - e0), 64'd1);
    chk("frames_after_f3", {32'd0, frames_loaded}, 64'd3);
    chk("pad_drained", 64'(q.size()), 64'd0);
    pulse_done();

    // Frame 4: no s_last on the final beat
    e0 = n_err;
    for (int i = 0; i < 8; i++) beat(64'(200 + i), 1'b0, 64'(200 + i), br[i]);
    wait_start();
    chk("missing_last_err", 64'(n_err - e0), 64'd1);
    chk("frames_after_f4", {32'd0, frames_loaded}, 64'd4);
    pulse_done();

    // Next frame restarts at addr 0; reset lands after 3 beats
    for (int i = 0; i < 3; i++) beat(64'(300 + i), 1'b0, 64'(300 + i), br[i]);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    q.delete();
    prev_cv = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    beat(64'h9, 1'b0, 64'h9, 0);
    idle(3);
    chk("final_drain", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
